// File: rtl/clint_axi_pkg.sv
// Shared constants for the CLINT AXI4 single-beat initiator: response codes,
// FSM encoding, default CLINT register addresses and the timeout counter width.
package clint_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [31:0] CLINT_MSIP0_ADDR = 32'h0200_0000;
  localparam logic [31:0] CLINT_MSIP1_ADDR = 32'h0200_0004;
  localparam logic [31:0] CLINT_SSIP0_ADDR = 32'h0200_C000;
  localparam logic [31:0] CLINT_SSIP1_ADDR = 32'h0200_C004;

  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_ERR   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // EXOKAY counts as success; only SLVERR/DECERR flag an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/clint_axi_resp_timer.sv
// Response watchdog for clint_axi_master: counts cycles spent waiting on the
// slave and flags expiry after TIMEOUT_CYCLES cycles (CLINT_MST_TIMEOUT_EN builds).
module clint_axi_resp_timer
  import clint_axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  // The first waiting cycle sees cnt = 0, so expiry lands on the TIMEOUT_CYCLES-th one.
  assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/clint_axi_master.sv
// Single-beat AXI4 initiator for CLINT MSIP/SSIP access: one request in, AW+W+B or
// AR+R out, one completion pulse back. Optional watchdog: define CLINT_MST_TIMEOUT_EN.
module clint_axi_master
  import clint_axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  state_e      state, state_nxt;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        aw_done, w_done, b_done, ar_done;
  logic        accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        write_fin, timeout;

  assign accept = req_valid && req_ready;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;

  // Handshakes of the current cycle count, so zero-wait slaves finish without a bubble.
  assign write_fin = (aw_done || aw_hs) && (w_done || w_hs) && (b_done || b_hs);

`ifdef CLINT_MST_TIMEOUT_EN
  clint_axi_resp_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .aclk    (aclk),
    .areset  (areset),
    .clear   (accept),
    .run     ((state == ST_WRITE) || (state == ST_READ)),
    .expired (timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout    = 1'b0;
`endif

  // rlast is redundant for single-beat reads; only resp bit 1 carries error meaning.
  logic unused_in;
  assign unused_in = ^{rlast, bresp[0], rresp[0]};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_addr[1:0] != 2'b00) state_nxt = ST_ERR;
          else if (req_we)            state_nxt = ST_WRITE;
          else                        state_nxt = ST_READ;
        end
      end
      ST_WRITE: if (write_fin || timeout) state_nxt = ST_DONE;
      ST_READ:  if (r_hs || timeout)      state_nxt = ST_DONE;
      ST_ERR:   state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (!areset) begin
      unique case (state)
        ST_IDLE:  req_ready = 1'b1;
        ST_WRITE: begin
          awvalid = !aw_done;
          wvalid  = !w_done;
          wlast   = !w_done;
          bready  = !b_done;
        end
        ST_READ: begin
          arvalid = !ar_done;
          rready  = 1'b1;
        end
        ST_DONE: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          resp_rdata = we_q ? '0 : rdata_q;
        end
        default: ;
      endcase
    end
    awaddr = awvalid ? addr_q  : '0;
    wdata  = wvalid  ? wdata_q : '0;
    araddr = arvalid ? addr_q  : '0;
  end

  // Per-channel completion flags, cleared whenever the FSM is idle.
  always_ff @(posedge aclk) begin
    if (areset || (state == ST_IDLE)) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      b_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs)  b_done  <= 1'b1;
      if (ar_hs) ar_done <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      err_q   <= (req_addr[1:0] != 2'b00);
    end else begin
      if (b_hs) err_q <= resp_is_err(bresp);
      if (r_hs) begin
        rdata_q <= rdata;
        err_q   <= resp_is_err(rresp);
      end
      if (timeout && !((state == ST_WRITE) ? write_fin : r_hs)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clint_axi_master.sv
// Self-checking bench for clint_axi_master: behavioural CLINT slave with wait-state
// and response knobs, a directed vector table, hand sequences and a random phase.
module tb_clint_axi_master;

  logic        aclk, areset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wlast, wvalid, wready, bready, bvalid;
  logic        arvalid, arready, rready, rvalid, rlast;
  logic [1:0]  bresp, rresp;

  clint_axi_master #(.TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bready(bready), .bresp(bresp), .bvalid(bvalid),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rdata(rdata), .rvalid(rvalid), .rresp(rresp), .rlast(rlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw_w, w_w, b_w, ar_w, r_w;
    logic [2:0]  ovr;
    logic        silent;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural CLINT slave ----------------
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [2:0]  ovr = 3'b000;
  logic        silent = 1'b0;
  logic [3:0]  clint_reg = 4'b0000;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic        ipi0;

  function automatic logic reg_hit(input logic [31:0] a);
    return (a == 32'h0200_0000) || (a == 32'h0200_0004) ||
           (a == 32'h0200_C000) || (a == 32'h0200_C004);
  endfunction

  function automatic logic [1:0] reg_sel(input logic [31:0] a);
    return {a[15], a[2]};
  endfunction

  assign ipi0    = clint_reg[0];
  assign awready = awvalid && !aw_got && (aw_cnt >= aw_wait) && !silent;
  assign wready  = wvalid && !w_got && (w_cnt >= w_wait) && !silent;
  assign bvalid  = aw_got && w_got && (b_cnt >= b_wait) && !silent;
  assign bresp   = ovr[2] ? ovr[1:0] : (reg_hit(s_awaddr) ? 2'b00 : 2'b11);
  assign arready = arvalid && !ar_got && (ar_cnt >= ar_wait) && !silent;
  assign rvalid  = ar_got && (r_cnt >= r_wait) && !silent;
  assign rresp   = ovr[2] ? ovr[1:0] : (reg_hit(s_araddr) ? 2'b00 : 2'b11);
  assign rdata   = reg_hit(s_araddr) ? {31'b0, clint_reg[reg_sel(s_araddr)]} : 32'h0;
  assign rlast   = rvalid;

  always @(posedge aclk) begin
    if (areset || resp_valid) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      if (awvalid && awready) begin aw_got <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0; end
      else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (wvalid && wready) begin w_got <= 1'b1; s_wdata <= wdata; w_cnt <= 0; end
      else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
      else w_cnt <= 0;
      if (bvalid && bready) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        if (reg_hit(s_awaddr) && !bresp[1]) clint_reg[reg_sel(s_awaddr)] <= s_wdata[0];
      end else if (aw_got && w_got) b_cnt <= b_cnt + 1;
      if (arvalid && arready) begin ar_got <= 1'b1; s_araddr <= araddr; ar_cnt <= 0; end
      else if (arvalid && !ar_got) ar_cnt <= ar_cnt + 1;
      else ar_cnt <= 0;
      if (rvalid && rready) begin ar_got <= 1'b0; r_cnt <= 0; end
      else if (ar_got) r_cnt <= r_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [3:0] m_reg = 4'b0000;

  function automatic void model(input vec_t v, output logic [31:0] rd, output logic er,
                                output int lat, output int awl, output int wl, output int arl);
    logic [1:0] resp;
    logic       hit;
    rd = '0; awl = 0; wl = 0; arl = 0;
    if (v.addr[1:0] != 2'b00) begin
      er = 1'b1; lat = 2;
      return;
    end
    hit  = reg_hit(v.addr);
    resp = v.ovr[2] ? v.ovr[1:0] : (hit ? 2'b00 : 2'b11);
    er   = resp[1];
    if (v.we) begin
      lat = 3 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + v.b_w;
      awl = 1 + v.aw_w;
      wl  = 1 + v.w_w;
      if (hit && !resp[1]) m_reg[reg_sel(v.addr)] = v.wdata[0];
    end else begin
      lat = 3 + v.ar_w + v.r_w;
      arl = 1 + v.ar_w;
      rd  = hit ? {31'b0, m_reg[reg_sel(v.addr)]} : 32'h0;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input int aw, input int w, input int b, input int ar, input int r,
                               input logic [2:0] ov, input logic [31:0] erd, input logic eer,
                               input int elat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd;
    v.aw_w = aw; v.w_w = w; v.b_w = b; v.ar_w = ar; v.r_w = r;
    v.ovr = ov; v.silent = 1'b0;
    v.exp_rdata = erd; v.exp_err = eer; v.exp_lat = elat;
    return v;
  endfunction

  task automatic run_txn(input string tag, input vec_t v, output logic [31:0] rd, output logic er,
                         output int lat, output int awl, output int wl, output int arl);
    int          n;
    logic        p_aw, p_w;
    logic [31:0] pa, pw;
    aw_wait = v.aw_w; w_wait = v.w_w; b_wait = v.b_w;
    ar_wait = v.ar_w; r_wait = v.r_w; ovr = v.ovr; silent = v.silent;
    @(negedge aclk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge aclk); n++; end
    @(negedge aclk);
    req_valid = 1'b0;
    lat = 0; awl = 0; wl = 0; arl = 0; rd = '0; er = 1'b0;
    p_aw = 1'b0; p_w = 1'b0; pa = '0; pw = '0;
    for (int c = 1; c <= 400; c++) begin
      if (p_aw) chk({tag, " aw_hold"}, (awvalid && awaddr == pa) ? 32'd1 : 32'd0, 32'd1);
      if (p_w)  chk({tag, " w_hold"}, (wvalid && wlast && wdata == pw) ? 32'd1 : 32'd0, 32'd1);
      if (awvalid) awl = c;
      if (wvalid)  wl  = c;
      if (arvalid) arl = c;
      if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; break; end
      p_aw = awvalid && !awready; pa = awaddr;
      p_w  = wvalid && !wready;   pw = wdata;
      @(negedge aclk);
    end
    @(negedge aclk);
    chk({tag, " single_pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic apply(input string tag, input vec_t v, input logic [31:0] erd, input logic eer,
                       input int elat, input int eawl, input int ewl, input int earl);
    logic [31:0] rd;
    logic        er;
    int          lat, awl, wl, arl;
    run_txn(tag, v, rd, er, lat, awl, wl, arl);
    chk({tag, " rdata"}, rd, erd);
    chk({tag, " err"}, {31'b0, er}, {31'b0, eer});
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " aw_last_cycle"}, 32'(awl), 32'(eawl));
    chk({tag, " w_last_cycle"}, 32'(wl), 32'(ewl));
    chk({tag, " ar_last_cycle"}, 32'(arl), 32'(earl));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t        tbl[14];
    vec_t        v;
    logic [31:0] mrd;
    logic        mer;
    int          mlat, mawl, mwl, marl;
    logic        seen;
    logic [31:0] base [4];

    tbl[0]  = mkv(1, 32'h0200_0000, 32'h1,         0, 0, 0, 0, 0, 3'b000, 32'h0, 0, 3);
    tbl[1]  = mkv(0, 32'h0200_0000, 32'h0,         0, 0, 0, 0, 0, 3'b000, 32'h1, 0, 3);
    tbl[2]  = mkv(1, 32'h0200_C004, 32'hFFFF_FFFF, 5, 0, 0, 0, 0, 3'b000, 32'h0, 0, 8);
    tbl[3]  = mkv(0, 32'h0200_C004, 32'h0,         0, 0, 0, 0, 0, 3'b000, 32'h1, 0, 3);
    tbl[4]  = mkv(1, 32'h0200_0004, 32'h1,         0, 0, 0, 0, 0, 3'b111, 32'h0, 1, 3);
    tbl[5]  = mkv(0, 32'h0200_0000, 32'h0,         0, 0, 0, 0, 0, 3'b110, 32'h1, 1, 3);
    tbl[6]  = mkv(1, 32'h0200_0002, 32'h1,         0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 2);
    tbl[7]  = mkv(0, 32'h0200_0001, 32'h0,         0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 2);
    tbl[8]  = mkv(0, 32'h0300_0000, 32'h0,         0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 3);
    tbl[9]  = mkv(0, 32'h0200_0004, 32'h0,         0, 0, 0, 2, 3, 3'b000, 32'h0, 0, 8);
    tbl[10] = mkv(1, 32'h0200_0004, 32'h3,         0, 0, 4, 0, 0, 3'b000, 32'h0, 0, 7);
    tbl[11] = mkv(0, 32'h0200_C000, 32'h0,         0, 0, 0, 0, 0, 3'b101, 32'h0, 0, 3);
    tbl[12] = mkv(1, 32'h0200_C000, 32'h1,         0, 3, 0, 0, 0, 3'b000, 32'h0, 0, 6);
    tbl[13] = mkv(0, 32'h0200_0004, 32'h0,         0, 0, 0, 0, 0, 3'b000, 32'h1, 0, 3);

    areset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge aclk);
    chk("reset ctl_outputs", {23'b0, req_ready, resp_valid, resp_err, awvalid, wvalid, wlast,
                              bready, arvalid, rready}, 32'd0);
    chk("reset data_outputs", resp_rdata | awaddr | wdata | araddr, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("idle req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      model(tbl[i], mrd, mer, mlat, mawl, mwl, marl);
      apply($sformatf("vec%0d", i), tbl[i], tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat,
            mawl, mwl, marl);
      if (i == 0) chk("ipi0 after msip0 write", {31'b0, ipi0}, 32'd1);
    end

    // Misaligned request while a second request waits behind it.
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; ovr = 3'b000;
    @(negedge aclk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0200_0002;
    chk("busy accept_ready", {31'b0, req_ready}, 32'd1);
    @(negedge aclk);
    req_addr = 32'h0200_0000;
    chk("busy c1 ready", {31'b0, req_ready}, 32'd0);
    chk("busy c1 no_axi", {30'b0, awvalid, arvalid}, 32'd0);
    chk("busy c1 no_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge aclk);
    chk("busy c2 resp", {30'b0, resp_valid, resp_err}, 32'd3);
    chk("busy c2 ready", {31'b0, req_ready}, 32'd0);
    chk("busy c2 no_axi", {30'b0, awvalid, arvalid}, 32'd0);
    @(negedge aclk);
    chk("busy c3 ready", {31'b0, req_ready}, 32'd1);
    @(negedge aclk);
    req_valid = 1'b0;
    mlat = 0; mrd = '0; mer = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (resp_valid) begin mlat = c; mrd = resp_rdata; mer = resp_err; break; end
      @(negedge aclk);
    end
    chk("busy second latency", 32'(mlat), 32'd3);
    chk("busy second rdata", mrd, {31'b0, m_reg[0]});
    chk("busy second err", {31'b0, mer}, 32'd0);

    // Reset while the write address is stalled.
    aw_wait = 20;
    @(negedge aclk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0200_0004; req_wdata = 32'h0;
    @(negedge aclk);
    req_valid = 1'b0;
    chk("midrst awvalid_before", {31'b0, awvalid}, 32'd1);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    chk("midrst ctl_outputs", {23'b0, req_ready, resp_valid, resp_err, awvalid, wvalid, wlast,
                               bready, arvalid, rready}, 32'd0);
    chk("midrst data_outputs", resp_rdata | awaddr | wdata | araddr, 32'd0);
    areset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (resp_valid || awvalid) seen = 1'b1;
    end
    chk("midrst no_resp_no_aw", {31'b0, seen}, 32'd0);
    chk("midrst idle_ready", {31'b0, req_ready}, 32'd1);
    aw_wait = 0;

`ifdef CLINT_MST_TIMEOUT_EN
    v = mkv(1, 32'h0200_0000, 32'h0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 9);
    v.silent = 1'b1;
    apply("timeout write", v, 32'h0, 1'b1, 9, 8, 8, 0);
    v = mkv(0, 32'h0200_0000, 32'h0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 9);
    v.silent = 1'b1;
    apply("timeout read", v, 32'h0, 1'b1, 9, 0, 0, 8);
    silent = 1'b0;
`endif

    base[0] = 32'h0200_0000; base[1] = 32'h0200_0004;
    base[2] = 32'h0200_C000; base[3] = 32'h0200_C004;
    for (int i = 0; i < 40; i++) begin
      int sel;
      v = mkv(1'($urandom_range(0, 1)), 32'h0, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 3'b000,
              32'h0, 1'b0, 0);
      sel = $urandom_range(0, 5);
      if (sel < 4) v.addr = base[sel];
      else if (sel == 4) begin
        v.addr = base[$urandom_range(0, 3)];
        v.addr[1:0] = 2'($urandom_range(1, 3));
      end else v.addr = 32'h0300_0000 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) v.ovr = {1'b1, 2'($urandom_range(0, 3))};
      model(v, mrd, mer, mlat, mawl, mwl, marl);
      apply($sformatf("rand%0d", i), v, mrd, mer, mlat, mawl, mwl, marl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
